// File: rtl/fir_controller.sv
// Sequencer for the time-multiplexed FIR datapath: accept, tap sweep, drain, output handshake.
// Define FIR_CTRL_OVERLAP_EN to allow a new sample to be accepted in the same cycle the result is taken.
module fir_controller #(
    parameter int FIR_size  = 64,
    parameter int AddrWidth = $clog2(FIR_size)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 shift,
    output logic                 flush,
    output logic                 freeze,
    output logic [AddrWidth-1:0] address,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [AddrWidth-1:0] LAST_ADDR = AddrWidth'(FIR_size - 1);

    state_t               state_q;
    logic [AddrWidth-1:0] addr_q;
    logic                 out_valid_q;
    logic                 ready_d;
    logic                 accept;

    // Ready is masked while reset is held so no sample is consumed during reset.
    always_comb begin
        ready_d = 1'b0;
        if (state_q == IDLE) begin
            ready_d = 1'b1;
        end
`ifdef FIR_CTRL_OVERLAP_EN
        else if (state_q == OUT) begin
            ready_d = out_ready;
        end
`endif
    end

    assign in_ready  = rst & ready_d;
    assign accept    = in_valid & in_ready;
    assign shift     = accept;
    assign flush     = accept;
    assign freeze    = (state_q != CALC);
    assign busy      = (state_q == CALC) || (state_q == DRAIN);
    assign address   = addr_q;
    assign out_valid = out_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    addr_q <= '0;
                    if (accept) begin
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (addr_q == LAST_ADDR) begin
                        addr_q  <= '0;
                        state_q <= DRAIN;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    // Last product lands in the accumulator while the multiply pipe loads zero.
                    addr_q      <= '0;
                    state_q     <= OUT;
                    out_valid_q <= 1'b1;
                end
                OUT: begin
                    addr_q <= '0;
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= accept ? CALC : IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    addr_q      <= '0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_controller.sv
// Directed bench for fir_controller: reset, tap sweep, backpressure, throughput, mid-run reset.
module tb_fir_controller;

    localparam int N  = 64;
    localparam int AW = 6;
`ifdef FIR_CTRL_OVERLAP_EN
    localparam int PERIOD  = N + 2;
    localparam bit OVERLAP = 1'b1;
`else
    localparam int PERIOD  = N + 3;
    localparam bit OVERLAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic          shift;
    logic          flush;
    logic          freeze;
    logic [AW-1:0] address;
    logic          busy;

    int ncmp = 0;
    int nerr = 0;
    int cnt;
    bit seen;

    always #5 clk = ~clk;

    fir_controller #(.FIR_size(N), .AddrWidth(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .shift    (shift),
        .flush    (flush),
        .freeze   (freeze),
        .address  (address),
        .busy     (busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        repeat (3) step();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_shift", int'(shift), 0);
        check("rst_flush", int'(flush), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_address", int'(address), 0);

        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_out_valid", int'(out_valid), 0);
        check("idle_address", int'(address), 0);
        check("idle_freeze", int'(freeze), 1);
        check("idle_shift", int'(shift), 0);
        step();
        check("idle_hold_busy", int'(busy), 0);

        // Single sample accepted at cycle T
        in_valid = 1'b1;
        #1;
        check("acc_shift", int'(shift), 1);
        check("acc_flush", int'(flush), 1);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            #0;
            check("calc_address", int'(address), k);
            check("calc_freeze", int'(freeze), 0);
            check("calc_busy", int'(busy), 1);
            check("calc_in_ready", int'(in_ready), 0);
            check("calc_out_valid", int'(out_valid), 0);
            step();
        end
        check("drain_freeze", int'(freeze), 1);
        check("drain_busy", int'(busy), 1);
        check("drain_address", int'(address), 0);
        check("drain_out_valid", int'(out_valid), 0);
        step();
        check("out_valid_rise", int'(out_valid), 1);
        check("out_busy", int'(busy), 0);
        check("out_freeze", int'(freeze), 1);

        // Backpressure with a waiting sample
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #0;
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_shift", int'(shift), 0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("rel_in_ready", int'(in_ready), int'(OVERLAP));
        check("rel_shift", int'(shift), int'(OVERLAP));
        check("rel_flush", int'(flush), int'(OVERLAP));
        step();
        check("post_rel_out_valid", int'(out_valid), 0);
        check("post_rel_busy", int'(busy), int'(OVERLAP));
        check("post_rel_address", int'(address), 0);
        check("post_rel_freeze", int'(freeze), int'(!OVERLAP));
        check("post_rel_shift", int'(shift), int'(!OVERLAP));

        // Withdraw the sample and let everything settle back to IDLE
        in_valid = 1'b0;
        cnt = 0;
        while (!(in_ready && !busy && !out_valid) && cnt < 200) begin
            step();
            cnt++;
        end
        check("settle_timeout", int'(cnt < 200), 1);

        // Back-to-back throughput with out_ready tied high
        in_valid = 1'b1;
        #1;
        check("tp_first_accept", int'(shift), 1);
        for (int p = 0; p < 3; p++) begin
            cnt = 0;
            do begin
                step();
                cnt++;
            end while (!shift && cnt < 200);
            check("tp_period", cnt, PERIOD);
        end
        in_valid = 1'b0;
        cnt = 0;
        while (!(in_ready && !busy && !out_valid) && cnt < 200) begin
            step();
            cnt++;
        end
        check("settle2_timeout", int'(cnt < 200), 1);

        // Reset asserted mid-sweep at address 30
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cnt = 0;
        while (address != AW'(30) && cnt < 100) begin
            step();
            cnt++;
        end
        check("reach_addr30", int'(address), 30);
        check("addr30_busy", int'(busy), 1);
        in_valid = 1'b1;
        rst      = 1'b0;
        #1;
        check("midrst_address", int'(address), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_shift", int'(shift), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("after_rst_in_ready", int'(in_ready), 1);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        check("abandoned_no_out_valid", int'(seen), 0);

        // Fresh sample after reset completes normally
        in_valid = 1'b1;
        #1;
        check("fresh_flush", int'(flush), 1);
        step();
        in_valid = 1'b0;
        repeat (N + 1) step();
        check("fresh_out_valid", int'(out_valid), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
